// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF) and load/store (LS),
// with LS priority, a starvation guard for IF, one outstanding transaction and a watchdog timeout.
module rv32i_mem_arbiter #(
    parameter int MAX_LS_RUN     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RUN_MAX = 4'(MAX_LS_RUN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    run_cnt_r;
    logic [TW-1:0] tcnt_r;
    logic          owner_ls_r;
    logic          mem_req_r, mem_we_r;
    logic [31:0]   mem_addr_r, mem_wdata_r;
    logic [3:0]    mem_wstrb_r;
    logic          if_rvalid_r, ls_rvalid_r, if_err_r, ls_err_r;
    logic [31:0]   if_rdata_r, ls_rdata_r;
    logic          if_win_s, ls_win_s, expire_s, done_s, abort_s;
    logic [31:0]   rsp_data_s;

    // Next-state, winner selection and completion/abort decode
    always_comb begin
        state_s  = state_r;
        if_win_s = 1'b0;
        ls_win_s = 1'b0;
        done_s   = 1'b0;
        abort_s  = 1'b0;
        expire_s = (tcnt_r == TLAST);
        case (state_r)
            ST_IDLE: begin
                // A grant during reset would be discarded by the edge, so none is offered.
                if (rst) begin
                    state_s = ST_IDLE;
                end else if (ls_req && (!if_req || (run_cnt_r != RUN_MAX))) begin
                    ls_win_s = 1'b1;
                    state_s  = ST_REQ;
                end else if (if_req) begin
                    if_win_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (mem_ready) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RSP: begin
                // A response arriving in the expiry cycle still counts as a normal completion.
                if (mem_rvalid) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (expire_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (done_s && !mem_we_r) begin
            rsp_data_s = mem_rdata;
        end else begin
            rsp_data_s = 32'h0000_0000;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latching, counters and registered response pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_r   <= 4'd0;
            tcnt_r      <= {TW{1'b0}};
            owner_ls_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            if_err_r    <= 1'b0;
            ls_err_r    <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            ls_rdata_r  <= 32'h0000_0000;
        end else begin
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            if_err_r    <= 1'b0;
            ls_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (if_win_s || ls_win_s) begin
                        owner_ls_r  <= ls_win_s;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= ls_win_s & ls_we;
                        mem_addr_r  <= ls_win_s ? ls_addr : if_addr;
                        mem_wdata_r <= ls_win_s ? ls_wdata : 32'h0000_0000;
                        mem_wstrb_r <= (ls_win_s && ls_we) ? ls_wstrb : 4'b0000;
                        tcnt_r      <= {TW{1'b0}};
                        // Only LS grants that make a waiting IF wait longer extend the run.
                        run_cnt_r   <= (ls_win_s && if_req) ? (run_cnt_r + 4'd1) : 4'd0;
                    end
                end
                ST_REQ: begin
                    tcnt_r <= tcnt_r + TW'(1);
                    if (expire_s || mem_ready) begin
                        mem_req_r <= 1'b0;
                    end
                end
                ST_RSP: begin
                    tcnt_r <= tcnt_r + TW'(1);
                end
                default: begin
                    tcnt_r <= {TW{1'b0}};
                end
            endcase
            if (done_s || abort_s) begin
                if (owner_ls_r) begin
                    ls_rvalid_r <= 1'b1;
                    ls_err_r    <= abort_s;
                    ls_rdata_r  <= rsp_data_s;
                end else begin
                    if_rvalid_r <= 1'b1;
                    if_err_r    <= abort_s;
                    if_rdata_r  <= rsp_data_s;
                end
            end
        end
    end

    assign if_gnt    = if_win_s;
    assign ls_gnt    = ls_win_s;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign if_rvalid = if_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign if_err    = if_err_r;
    assign ls_rvalid = ls_rvalid_r;
    assign ls_rdata  = ls_rdata_r;
    assign ls_err    = ls_err_r;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_rv32i_mem_arbiter;

    localparam int MAX_RUN = 4;
    localparam int TMO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic [3:0]  ls_wstrb = 4'h0;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    rv32i_mem_arbiter #(.MAX_LS_RUN(MAX_RUN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one in-flight transaction, its age, and the response due next cycle.
    bit          m_busy = 1'b0, m_acc = 1'b0, m_own_ls = 1'b0, m_we = 1'b0;
    int          m_age = 0, m_run = 0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic [3:0]  m_wstrb = 4'h0;
    bit          e_if_rv = 1'b0, e_ls_rv = 1'b0, e_err = 1'b0;
    logic [31:0] e_rdata = 32'h0;

    initial begin : compare
        bit          g_if, g_ls, fin, err_f;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            #1;
            g_if = 1'b0;
            g_ls = 1'b0;
            if (!rst && !m_busy) begin
                if (ls_req && !(if_req && m_run == MAX_RUN)) g_ls = 1'b1;
                else if (if_req) g_if = 1'b1;
            end
            chk1("if_gnt", if_gnt, g_if);
            chk1("ls_gnt", ls_gnt, g_ls);
            chk1("mem_req", mem_req, m_busy && !m_acc);
            if (m_busy && !m_acc) begin
                chk1("mem_we", mem_we, m_we);
                chk32("mem_addr", mem_addr, m_addr);
                chk32("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_wstrb});
                if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
            end
            chk1("if_rvalid", if_rvalid, e_if_rv);
            chk1("ls_rvalid", ls_rvalid, e_ls_rv);
            chk1("if_err", if_err, e_if_rv && e_err);
            chk1("ls_err", ls_err, e_ls_rv && e_err);
            if (e_if_rv) chk32("if_rdata", if_rdata, e_rdata);
            if (e_ls_rv) chk32("ls_rdata", ls_rdata, e_rdata);

            // Advance the model across the coming rising edge.
            fin = 1'b0;
            err_f = 1'b0;
            d = 32'h0;
            e_if_rv = 1'b0;
            e_ls_rv = 1'b0;
            e_err = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
                m_acc = 1'b0;
                m_run = 0;
            end else if (!m_busy) begin
                if (g_ls || g_if) begin
                    m_busy = 1'b1;
                    m_acc = 1'b0;
                    m_age = 0;
                    m_own_ls = g_ls;
                    m_we = g_ls && ls_we;
                    m_addr = g_ls ? ls_addr : if_addr;
                    m_wdata = ls_wdata;
                    m_wstrb = m_we ? ls_wstrb : 4'h0;
                    m_run = (g_ls && if_req) ? m_run + 1 : 0;
                end
            end else begin
                if (m_acc && mem_rvalid) begin
                    fin = 1'b1;
                    d = m_we ? 32'h0 : mem_rdata;
                end else if (m_age == TMO - 1) begin
                    fin = 1'b1;
                    err_f = 1'b1;
                end else if (!m_acc && mem_ready) begin
                    m_acc = 1'b1;
                end
                m_age++;
                if (fin) begin
                    m_busy = 1'b0;
                    e_if_rv = !m_own_ls;
                    e_ls_rv = m_own_ls;
                    e_err = err_f;
                    e_rdata = d;
                end
            end
        end
    end

    initial begin : stimulus
        string seq;
        int    n;
        bit    if_pend, ls_pend;

        // Reset: outputs quiet, no grant even with a request present.
        @(negedge clk);
        rst = 1'b1;
        ls_req = 1'b1;
        #2;
        chk1("rst_ls_gnt", ls_gnt, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);

        // Single load.
        @(negedge clk);
        rst = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; mem_ready = 1'b1;
        #2;
        chk1("load_gnt", ls_gnt, 1'b1);
        chk1("load_if_gnt", if_gnt, 1'b0);
        @(negedge clk);
        ls_req = 1'b0;
        #2;
        chk1("load_mem_req", mem_req, 1'b1);
        chk32("load_mem_addr", mem_addr, 32'h100);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #2;
        chk1("load_early_rvalid", ls_rvalid, 1'b0);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_ready = 1'b0;
        #2;
        chk1("load_rvalid", ls_rvalid, 1'b1);
        chk32("load_rdata", ls_rdata, 32'hDEAD_BEEF);
        chk1("load_if_quiet", if_rvalid, 1'b0);

        // Store held through three stall cycles.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_wstrb = 4'b0011;
        #2;
        chk1("store_gnt", ls_gnt, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ls_req = 1'b0;
            #2;
            chk1("store_stall_req", mem_req, 1'b1);
            chk1("store_stall_we", mem_we, 1'b1);
            chk32("store_stall_wstrb", {28'd0, mem_wstrb}, 32'h3);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #2;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        #2;
        @(negedge clk);
        mem_rvalid = 1'b0; ls_we = 1'b0;
        #2;
        chk1("store_ack", ls_rvalid, 1'b1);
        chk32("store_rdata", ls_rdata, 32'h0);

        // Contention with both requests held.
        seq = "";
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_addr = 32'h380;
            mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0000;
            #2;
            if (ls_gnt) begin seq = {seq, "L"}; n++; end
            else if (if_gnt) begin seq = {seq, "I"}; n++; end
        end
        checks++;
        if (seq != "LLLLIL") begin
            errors++;
            $display("FAIL grant_seq: got %s expected LLLLIL", seq);
        end
        repeat (4) begin
            @(negedge clk);
            if_req = 1'b0; ls_req = 1'b0;
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0;

        // Fetch timeout; a late response is ignored.
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if_req = (k == 0); if_addr = 32'h400;
            mem_ready = 1'b0; mem_rvalid = (k == 10); mem_rdata = 32'h7777_7777;
            #2;
            if (k == 0) chk1("tmo_gnt", if_gnt, 1'b1);
            chk1("tmo_mem_req", mem_req, (k >= 1 && k <= 8));
            chk1("tmo_rvalid", if_rvalid, (k == 9));
            if (k == 9) begin
                chk1("tmo_err", if_err, 1'b1);
                chk32("tmo_rdata", if_rdata, 32'h0);
            end
        end

        // Reset while waiting in the response phase, then a normal fetch.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; mem_ready = 1'b1; mem_rvalid = 1'b0;
        #2;
        chk1("rstrsp_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        #2;
        @(negedge clk);
        mem_ready = 1'b0; rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b1;
        #2;
        chk1("rstrsp_mem_req", mem_req, 1'b0);
        chk1("rstrsp_no_rvalid", ls_rvalid, 1'b0);
        chk1("rstrsp_if_gnt", if_gnt, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        #2;
        chk32("rstrsp_addr", mem_addr, 32'h600);
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #2;
        chk1("rstrsp_ls_quiet", ls_rvalid, 1'b0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #2;
        chk1("rstrsp_if_rvalid", if_rvalid, 1'b1);
        chk32("rstrsp_if_rdata", if_rdata, 32'hCAFE_F00D);

        // Response in the same cycle as expiry wins.
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if_req = (k == 0); if_addr = 32'h700;
            mem_ready = (k == 7); mem_rvalid = (k == 8); mem_rdata = 32'h0BAD_F00D;
            #2;
            if (k == 8) chk1("race_early", if_rvalid, 1'b0);
            if (k == 9) begin
                chk1("race_rvalid", if_rvalid, 1'b1);
                chk1("race_err", if_err, 1'b0);
                chk32("race_rdata", if_rdata, 32'h0BAD_F00D);
            end
        end

        // Randomized traffic; requests are held until granted or occasionally withdrawn.
        if_pend = 1'b0;
        ls_pend = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (if_pend && $urandom_range(0, 29) == 0) begin
                if_pend = 1'b0;
            end
            if (!ls_pend && $urandom_range(0, 2) == 0) begin
                ls_pend = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = $urandom;
                ls_wdata = $urandom;
                ls_wstrb = 4'($urandom_range(0, 15));
            end else if (ls_pend && $urandom_range(0, 29) == 0) begin
                ls_pend = 1'b0;
            end
            if_req = if_pend;
            ls_req = ls_pend;
            mem_ready = ($urandom_range(0, 9) < 6);
            mem_rvalid = ($urandom_range(0, 9) < 4);
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            #2;
            if (if_gnt) if_pend = 1'b0;
            if (ls_gnt) ls_pend = 1'b0;
        end

        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; rst = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
